// File: rtl/buf_wr_arb_pkg.sv
// Shared types and helpers for the buffer write-port arbiter.
// Imported by the arbiter top and its round-robin selector.
package buf_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic int wrap_inc(
    input int i,
    input int n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/buf_wr_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or
// after the pointer, wrapping; one-hot winner plus its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int p;
    logic [IW-1:0] q;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    p     = 0;
    q     = '0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr_i) + k;
      if (p >= N) p = p - N;
      q = IW'(p);
      if (!any_o && req_i[q]) begin
        any_o    = 1'b1;
        gnt_o[q] = 1'b1;
        idx_o    = q;
      end
    end
  end

endmodule

// File: rtl/buf_wr_arb.sv
// Round-robin burst arbiter driving the source-side write port
// of the dual-clock buffer; never writes while the buffer is full.
module buf_wr_arb
  import buf_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          iclk,
  input  logic                          irst_n,
  input  logic [NUM_REQ-1:0]            ireq,
  input  logic [NUM_REQ-1:0]            ilast,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] idata,
  input  logic                          ifull,
  output logic [NUM_REQ-1:0]            ogrant,
  output logic                          owr,
  output logic [DATA_WIDTH-1:0]         odata,
  output logic                          obusy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST);

  state_e                  state_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    busy_q;
  logic [PW-1:0]           ptr_q;
  logic [PW-1:0]           ptr_d;
  logic [PW-1:0]           gidx_q;
  logic [BW-1:0]           beat_q;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [PW-1:0]           pick_idx;
  logic                    pick_any;

  logic                    req_g;
  logic                    last_g;
  logic                    accept;
  logic                    beat_max;
  logic                    done;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (PW)
  ) u_pick (
    .req_i (ireq),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Only the granted lane's request/last matter.
  assign req_g    = |(ireq & gnt_q);
  assign last_g   = |(ilast & gnt_q);
  assign accept   = req_g & ~ifull;
  assign beat_max = (beat_q == BW'(MAX_BURST - 1));
  assign done     = (accept & (last_g | beat_max))
                  | (~req_g & ~ifull);

  assign data_d = accept
    ? idata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH]
    : data_q;
  assign ptr_d  = PW'(wrap_inc(int'(gidx_q), NUM_REQ));

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          wr_q <= 1'b0;
          if (pick_any) begin
            gnt_q   <= pick_gnt;
            gidx_q  <= pick_idx;
            busy_q  <= 1'b1;
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          wr_q   <= accept;
          data_q <= data_d;
          if (accept && !beat_max) begin
            beat_q <= beat_q + BW'(1);
          end
          if (done) begin
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign ogrant = gnt_q;
  assign owr    = wr_q;
  assign odata  = data_q;
  assign obusy  = busy_q;

endmodule

// File: tb/tb_buf_wr_arb.sv
// Scoreboard bench for buf_wr_arb: word-level reference model
// pushes expected outputs, a negedge monitor pops and compares.
module tb_buf_wr_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  typedef struct {
    logic [N-1:0]  g;
    logic          wr;
    logic [DW-1:0] d;
    logic          busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] data;
  logic            full;
  logic [N-1:0]    ogrant;
  logic            owr;
  logic [DW-1:0]   odata;
  logic            obusy;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit            m_busy;
  int            m_g;
  int            m_ptr;
  int            m_words;
  logic          m_wr;
  logic [DW-1:0] m_d;
  exp_t          m_e;
  exp_t          mon_e;

  buf_wr_arb #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .ireq   (req),
    .ilast  (last),
    .idata  (data),
    .ifull  (full),
    .ogrant (ogrant),
    .owr    (owr),
    .odata  (odata),
    .obusy  (obusy)
  );

  initial forever #5 clk = ~clk;

  // Reference: burst = grant, words counted until last/MB/abandon.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  = 0;
      m_g     = 0;
      m_ptr   = 0;
      m_words = 0;
      m_wr    = 1'b0;
      m_d     = '0;
    end else if (!m_busy) begin
      m_wr = 1'b0;
      if (req != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        m_busy  = 1;
        m_words = 0;
      end
    end else begin
      m_wr = req[m_g] && !full;
      if (m_wr) begin
        m_d = data[m_g*DW +: DW];
        m_words++;
      end
      if ((m_wr && (last[m_g] || m_words == MB)) ||
          (!req[m_g] && !full)) begin
        m_busy = 0;
        m_ptr  = (m_g + 1) % N;
      end
    end
    m_e.g    = m_busy ? N'(1 << m_g) : '0;
    m_e.wr   = m_wr;
    m_e.d    = m_d;
    m_e.busy = m_busy;
    sbq.push_back(m_e);
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, a, x, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() == 0) begin
      chk("queue_nonempty", 32'd0, 32'd1);
    end else begin
      mon_e = sbq.pop_front();
      chk("ogrant", 32'(ogrant), 32'(mon_e.g));
      chk("obusy", 32'(obusy), 32'(mon_e.busy));
      chk("owr", 32'(owr), 32'(mon_e.wr));
      chk("odata", 32'(odata), 32'(mon_e.d));
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l,
                     input logic f, input logic rs = 1'b1);
    @(posedge clk);
    #1;
    req   = r;
    last  = l;
    full  = f;
    rst_n = rs;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    int wc[N];
    logic [N-1:0] r;
    logic [N-1:0] l;
    rst_n = 1'b0;
    req   = '0;
    last  = '0;
    full  = 1'b0;
    data  = '0;
    repeat (3) cyc('0, '0, 1'b0, 1'b0);
    cyc('0, '0, 1'b0);

    // single requester, three words
    cyc(4'b0010, '0, 1'b0);
    cyc(4'b0010, '0, 1'b0);
    cyc(4'b0010, '0, 1'b0);
    cyc(4'b0010, 4'b0010, 1'b0);
    repeat (2) cyc('0, '0, 1'b0);

    // all requesting, 2-word bursts
    for (int i = 0; i < N; i++) wc[i] = 0;
    repeat (28) begin
      for (int i = 0; i < N; i++) l[i] = ogrant[i] && wc[i] == 1;
      cyc('1, l, 1'b0);
      for (int i = 0; i < N; i++)
        if (ogrant[i]) wc[i] = last[i] ? 0 : wc[i] + 1;
    end
    repeat (2) cyc('0, '0, 1'b0);

    // forced release on long stream
    repeat (30) cyc(4'b0100, '0, 1'b0);
    repeat (12) cyc(4'b0101, '0, 1'b0);
    repeat (2) cyc('0, '0, 1'b0);

    // back-pressure mid-burst
    repeat (3) cyc(4'b0001, '0, 1'b0);
    repeat (5) cyc(4'b0001, '0, 1'b1);
    repeat (2) cyc(4'b0001, '0, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b0);
    repeat (2) cyc('0, '0, 1'b0);

    // abandon after one word
    cyc(4'b1000, '0, 1'b0);
    cyc(4'b1000, '0, 1'b0);
    repeat (3) cyc(4'b0000, '0, 1'b0);

    // reset during third word
    repeat (3) cyc(4'b0001, '0, 1'b0);
    cyc(4'b1111, '0, 1'b0, 1'b0);
    repeat (4) cyc(4'b1111, '0, 1'b0);
    repeat (2) cyc('0, '0, 1'b0);

    // randomized traffic
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(3) != 0);
        l[i] = ($urandom_range(3) == 0);
      end
      cyc(r, l, $urandom_range(3) == 0, $urandom_range(99) != 0);
    end
    repeat (4) cyc('0, '0, 1'b0);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
